// File: rtl/axil_arb_pkg.sv
// Shared constants for the two-master AXI-Lite arbiter in front of the FIR
// configuration port: FSM state encodings and one-hot grant encodings.
package axil_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WR    = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/axil_rr_pick.sv
// Two-input round-robin picker. The master pointed to by rr_ptr wins when it
// requests; otherwise the other master wins. Purely combinational; the
// parent owns and advances rr_ptr.
module axil_rr_pick
    import axil_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    // Preferred master first, then the other one.
    always_comb begin
        grant = GNT_NONE;
        if (rr_ptr == 1'b0) begin
            if (req[0])      grant = GNT_M0;
            else if (req[1]) grant = GNT_M1;
        end else begin
            if (req[1])      grant = GNT_M1;
            else if (req[0]) grant = GNT_M0;
        end
    end

endmodule

// File: rtl/axilite_arbiter2.sv
// Two-master to one-slave AXI-Lite arbiter for the FIR configuration port
// (AW/W/AR/R only, no B channel). Round-robin arbitration; a grant is held
// until the whole write (AW and W) or read (AR then R) has completed.
// Optional build macro AXIL_ARB_PERF_EN adds saturating per-master
// completed-transaction counters; without it the counter ports are tied to 0.
module axilite_arbiter2
    import axil_arb_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   m0_awvalid,
    output logic                   m0_awready,
    input  logic [pADDR_WIDTH-1:0] m0_awaddr,
    input  logic                   m0_wvalid,
    output logic                   m0_wready,
    input  logic [pDATA_WIDTH-1:0] m0_wdata,
    input  logic                   m0_arvalid,
    output logic                   m0_arready,
    input  logic [pADDR_WIDTH-1:0] m0_araddr,
    output logic                   m0_rvalid,
    input  logic                   m0_rready,
    output logic [pDATA_WIDTH-1:0] m0_rdata,

    input  logic                   m1_awvalid,
    output logic                   m1_awready,
    input  logic [pADDR_WIDTH-1:0] m1_awaddr,
    input  logic                   m1_wvalid,
    output logic                   m1_wready,
    input  logic [pDATA_WIDTH-1:0] m1_wdata,
    input  logic                   m1_arvalid,
    output logic                   m1_arready,
    input  logic [pADDR_WIDTH-1:0] m1_araddr,
    output logic                   m1_rvalid,
    input  logic                   m1_rready,
    output logic [pDATA_WIDTH-1:0] m1_rdata,

    output logic                   s_awvalid,
    input  logic                   s_awready,
    output logic [pADDR_WIDTH-1:0] s_awaddr,
    output logic                   s_wvalid,
    input  logic                   s_wready,
    output logic [pDATA_WIDTH-1:0] s_wdata,
    output logic                   s_arvalid,
    input  logic                   s_arready,
    output logic [pADDR_WIDTH-1:0] s_araddr,
    input  logic                   s_rvalid,
    output logic                   s_rready,
    input  logic [pDATA_WIDTH-1:0] s_rdata,

    output logic [1:0]             grant,
    output logic                   busy,
    output logic [pCNT_WIDTH-1:0]  m0_xfer_cnt,
    output logic [pCNT_WIDTH-1:0]  m1_xfer_cnt
);

    logic [1:0] r_state;
    logic [1:0] r_grant;
    logic       r_rr_ptr;
    logic       r_aw_done;
    logic       r_w_done;
    logic       r_ar_done;

    // Request decode; a write request takes priority over a read from the
    // same master, so the picked master goes to WR whenever it has AW or W up.
    logic       w_req_wr0;
    logic       w_req_wr1;
    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic       w_pick_wr;

    assign w_req_wr0 = m0_awvalid | m0_wvalid;
    assign w_req_wr1 = m1_awvalid | m1_wvalid;
    assign w_req     = {w_req_wr1 | m1_arvalid, w_req_wr0 | m0_arvalid};
    assign w_pick_wr = w_pick[1] ? w_req_wr1 : w_req_wr0;

    axil_rr_pick u_pick (
        .req    (w_req),
        .rr_ptr (r_rr_ptr),
        .grant  (w_pick)
    );

    // Signals of the currently granted master (zero when nobody owns the bus).
    logic                   w_in_wr;
    logic                   w_in_rd;
    logic                   w_awvalid;
    logic                   w_wvalid;
    logic                   w_arvalid;
    logic                   w_rready;
    logic [pADDR_WIDTH-1:0] w_awaddr;
    logic [pADDR_WIDTH-1:0] w_araddr;
    logic [pDATA_WIDTH-1:0] w_wdata;

    assign w_in_wr   = (r_state == ST_WR);
    assign w_in_rd   = (r_state == ST_RD);
    assign w_awvalid = (r_grant[0] & m0_awvalid) | (r_grant[1] & m1_awvalid);
    assign w_wvalid  = (r_grant[0] & m0_wvalid)  | (r_grant[1] & m1_wvalid);
    assign w_arvalid = (r_grant[0] & m0_arvalid) | (r_grant[1] & m1_arvalid);
    assign w_rready  = (r_grant[0] & m0_rready)  | (r_grant[1] & m1_rready);
    assign w_awaddr  = r_grant[1] ? m1_awaddr : (r_grant[0] ? m0_awaddr : '0);
    assign w_araddr  = r_grant[1] ? m1_araddr : (r_grant[0] ? m0_araddr : '0);
    assign w_wdata   = r_grant[1] ? m1_wdata  : (r_grant[0] ? m0_wdata  : '0);

    // Slave side: each address/data valid is suppressed once its handshake
    // has been taken, so a late or misbehaving master cannot issue it twice.
    assign s_awvalid = w_in_wr & w_awvalid & ~r_aw_done;
    assign s_wvalid  = w_in_wr & w_wvalid  & ~r_w_done;
    assign s_arvalid = w_in_rd & w_arvalid & ~r_ar_done;
    assign s_rready  = w_in_rd & w_rready;
    assign s_awaddr  = w_awaddr;
    assign s_araddr  = w_araddr;
    assign s_wdata   = w_wdata;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_fin;
    logic w_rd_fin;

    assign w_aw_hs  = s_awvalid & s_awready;
    assign w_w_hs   = s_wvalid  & s_wready;
    assign w_ar_hs  = s_arvalid & s_arready;
    assign w_wr_fin = w_in_wr & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_rd_fin = w_in_rd & s_rvalid & s_rready;

    // Master side: readies, rvalid and rdata reach the owner only.
    logic w_awready_g;
    logic w_wready_g;
    logic w_arready_g;
    logic w_rvalid_g;

    assign w_awready_g = w_in_wr & s_awready & ~r_aw_done;
    assign w_wready_g  = w_in_wr & s_wready  & ~r_w_done;
    assign w_arready_g = w_in_rd & s_arready & ~r_ar_done;
    assign w_rvalid_g  = w_in_rd & s_rvalid;

    assign m0_awready = r_grant[0] & w_awready_g;
    assign m0_wready  = r_grant[0] & w_wready_g;
    assign m0_arready = r_grant[0] & w_arready_g;
    assign m0_rvalid  = r_grant[0] & w_rvalid_g;
    assign m0_rdata   = (r_grant[0] & w_in_rd) ? s_rdata : '0;

    assign m1_awready = r_grant[1] & w_awready_g;
    assign m1_wready  = r_grant[1] & w_wready_g;
    assign m1_arready = r_grant[1] & w_arready_g;
    assign m1_rvalid  = r_grant[1] & w_rvalid_g;
    assign m1_rdata   = (r_grant[1] & w_in_rd) ? s_rdata : '0;

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

    // Arbitration FSM: grant in IDLE, hold through WR/RD, hand the
    // round-robin pointer to the other master on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_rr_ptr  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick != GNT_NONE) begin
                        r_grant <= w_pick;
                        r_state <= w_pick_wr ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if (w_wr_fin) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= GNT_NONE;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_rr_ptr  <= r_grant[0];
                    end
                end
                ST_RD: begin
                    if (w_ar_hs) r_ar_done <= 1'b1;
                    if (w_rd_fin) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= GNT_NONE;
                        r_ar_done <= 1'b0;
                        r_rr_ptr  <= r_grant[0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

`ifdef AXIL_ARB_PERF_EN
    logic                  w_fin;
    logic [pCNT_WIDTH-1:0] r_cnt0;
    logic [pCNT_WIDTH-1:0] r_cnt1;

    assign w_fin = w_wr_fin | w_rd_fin;

    // Saturating completed-transaction counters, one per master.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_fin && r_grant[0] && !(&r_cnt0)) r_cnt0 <= r_cnt0 + pCNT_WIDTH'(1);
            if (w_fin && r_grant[1] && !(&r_cnt1)) r_cnt1 <= r_cnt1 + pCNT_WIDTH'(1);
        end
    end

    assign m0_xfer_cnt = r_cnt0;
    assign m1_xfer_cnt = r_cnt1;
`else
    assign m0_xfer_cnt = '0;
    assign m1_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_axilite_arbiter2.sv
// Directed bench for axilite_arbiter2. Expected slave-side AW/W/AR traffic,
// master-side read data and grant order are queued when stimulus is set up
// and checked by a negedge monitor as the DUT produces them.
module tb_axilite_arbiter2;

    logic        clk;
    logic        rst_n;
    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [11:0] m0_awaddr, m0_araddr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [11:0] m1_awaddr, m1_araddr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [11:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] m0_xfer_cnt, m1_xfer_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] q_aw[$];
    logic [63:0] q_w[$];
    logic [63:0] q_ar[$];
    logic [63:0] q_rd[$];
    logic [63:0] q_gnt[$];
    logic [1:0]  prev_gnt = 2'b00;

    axilite_arbiter2 dut (
        .clk(clk), .rst_n(rst_n),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .grant(grant), .busy(busy),
        .m0_xfer_cnt(m0_xfer_cnt), .m1_xfer_cnt(m1_xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic id, input logic [31:0] v);
        return {31'd0, id, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic all_idle();
        return !(m0_awvalid | m0_wvalid | m0_arvalid | m0_rready |
                 m1_awvalid | m1_wvalid | m1_arvalid | m1_rready | busy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of well-behaved masters: drop each valid/rready after its handshake.
    task automatic cycle_auto();
        logic h0aw, h0w, h0ar, h0r, h1aw, h1w, h1ar, h1r;
        @(negedge clk);
        h0aw = m0_awvalid & m0_awready; h0w = m0_wvalid & m0_wready;
        h0ar = m0_arvalid & m0_arready; h0r = m0_rvalid & m0_rready;
        h1aw = m1_awvalid & m1_awready; h1w = m1_wvalid & m1_wready;
        h1ar = m1_arvalid & m1_arready; h1r = m1_rvalid & m1_rready;
        tick();
        if (h0aw) m0_awvalid = 1'b0;
        if (h0w)  m0_wvalid  = 1'b0;
        if (h0ar) m0_arvalid = 1'b0;
        if (h0r)  m0_rready  = 1'b0;
        if (h1aw) m1_awvalid = 1'b0;
        if (h1w)  m1_wvalid  = 1'b0;
        if (h1ar) m1_arvalid = 1'b0;
        if (h1r)  m1_rready  = 1'b0;
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (n < max && !all_idle()) begin
            cycle_auto();
            n++;
        end
        chk(tag, {63'd0, all_idle()}, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: slave-side handshakes, master read data, grant order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_awvalid && s_awready) begin
                if (q_aw.size() == 0) chk("aw_unexpected", 64'(q_aw.size()), 64'd1);
                else chk("aw_addr", mk(grant[1], 32'(s_awaddr)), q_aw.pop_front());
            end
            if (s_wvalid && s_wready) begin
                if (q_w.size() == 0) chk("w_unexpected", 64'(q_w.size()), 64'd1);
                else chk("w_data", mk(grant[1], s_wdata), q_w.pop_front());
            end
            if (s_arvalid && s_arready) begin
                if (q_ar.size() == 0) chk("ar_unexpected", 64'(q_ar.size()), 64'd1);
                else chk("ar_addr", mk(grant[1], 32'(s_araddr)), q_ar.pop_front());
            end
            if (m0_rvalid && m0_rready) begin
                if (q_rd.size() == 0) chk("r0_unexpected", 64'(q_rd.size()), 64'd1);
                else chk("r0_data", mk(1'b0, m0_rdata), q_rd.pop_front());
            end
            if (m1_rvalid && m1_rready) begin
                if (q_rd.size() == 0) chk("r1_unexpected", 64'(q_rd.size()), 64'd1);
                else chk("r1_data", mk(1'b1, m1_rdata), q_rd.pop_front());
            end
            if (grant != 2'b00 && prev_gnt == 2'b00) begin
                if (q_gnt.size() == 0) chk("gnt_unexpected", 64'(q_gnt.size()), 64'd1);
                else chk("gnt_order", 64'(grant), q_gnt.pop_front());
            end
        end
        prev_gnt <= grant;
    end

    initial begin
        rst_n = 1'b0;
        m0_awvalid = 0; m0_wvalid = 0; m0_arvalid = 0; m0_rready = 0;
        m0_awaddr = 0; m0_araddr = 0; m0_wdata = 0;
        m1_awvalid = 0; m1_wvalid = 0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = 0; m1_araddr = 0; m1_wdata = 0;
        s_awready = 0; s_wready = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0;
        repeat (2) tick();

        // Reset state, with a master requesting and the slave driving read data
        m0_awvalid = 1; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_awready = 1;
        m1_rready = 1;
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        chk("rst_m0_awready", 64'(m0_awready), 64'd0);
        chk("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
        chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
        chk("rst_m1_rdata", 64'(m1_rdata), 64'd0);
        tick();
        rst_n = 1; m0_awvalid = 0; s_rvalid = 0; s_rdata = 0; m1_rready = 0;

        // Single write from m0 with slave readies held high
        s_awready = 1; s_wready = 1;
        m0_awaddr = 12'h010; m0_wdata = 32'h0000_0005; m0_awvalid = 1; m0_wvalid = 1;
        q_gnt.push_back(64'd1); q_aw.push_back(mk(0, 32'h010)); q_w.push_back(mk(0, 32'h5));
        @(negedge clk);
        chk("sw_arb_s_awvalid", 64'(s_awvalid), 64'd0);
        chk("sw_arb_grant", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("sw_s_awvalid", 64'(s_awvalid), 64'd1);
        chk("sw_s_wvalid", 64'(s_wvalid), 64'd1);
        chk("sw_m0_awready", 64'(m0_awready), 64'd1);
        chk("sw_m0_wready", 64'(m0_wready), 64'd1);
        chk("sw_m1_awready", 64'(m1_awready), 64'd0);
        chk("sw_grant", 64'(grant), 64'd1);
        tick();
        m0_awvalid = 0; m0_wvalid = 0;
        @(negedge clk);
        chk("sw_end_grant", 64'(grant), 64'd0);
        chk("sw_end_busy", 64'(busy), 64'd0);

        // Split handshake: AW accepted early, W much later; m0 keeps AWVALID up
        s_awready = 0; s_wready = 0;
        m0_awaddr = 12'h020; m0_wdata = 32'h0000_1234; m0_awvalid = 1; m0_wvalid = 1;
        q_gnt.push_back(64'd1); q_aw.push_back(mk(0, 32'h020)); q_w.push_back(mk(0, 32'h1234));
        tick();
        s_awready = 1;
        @(negedge clk);
        chk("split_aw_s_awvalid", 64'(s_awvalid), 64'd1);
        chk("split_aw_m0_wready", 64'(m0_wready), 64'd0);
        tick();
        s_awready = 0;
        @(negedge clk);
        chk("split_s_awvalid_dropped", 64'(s_awvalid), 64'd0);
        chk("split_s_wvalid", 64'(s_wvalid), 64'd1);
        chk("split_grant_mid", 64'(grant), 64'd1);
        tick(); tick();
        s_wready = 1;
        @(negedge clk);
        chk("split_grant_held", 64'(grant), 64'd1);
        chk("split_m0_wready", 64'(m0_wready), 64'd1);
        chk("split_s_awvalid_still0", 64'(s_awvalid), 64'd0);
        tick();
        m0_awvalid = 0; m0_wvalid = 0;
        @(negedge clk);
        chk("split_end_grant", 64'(grant), 64'd0);

        // Contention after reset: both masters write, twice -> 0,1,0,1
        do_reset();
        s_awready = 1; s_wready = 1;
        for (int r = 0; r < 2; r++) begin
            m0_awaddr = 12'h030 + 12'(r * 4); m0_wdata = 32'hA0 + 32'(r);
            m1_awaddr = 12'h040 + 12'(r * 4); m1_wdata = 32'hB0 + 32'(r);
            m0_awvalid = 1; m0_wvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
            q_gnt.push_back(64'd1); q_gnt.push_back(64'd2);
            q_aw.push_back(mk(0, 32'(m0_awaddr))); q_aw.push_back(mk(1, 32'(m1_awaddr)));
            q_w.push_back(mk(0, m0_wdata)); q_w.push_back(mk(1, m1_wdata));
            drain("cont_drain", 20);
        end
`ifdef AXIL_ARB_PERF_EN
        chk("cont_m0_cnt", 64'(m0_xfer_cnt), 64'd2);
        chk("cont_m1_cnt", 64'(m1_xfer_cnt), 64'd2);
`else
        chk("cont_m0_cnt_off", 64'(m0_xfer_cnt), 64'd0);
        chk("cont_m1_cnt_off", 64'(m1_xfer_cnt), 64'd0);
`endif

        // m1 read with slave latency; m0 must see nothing
        s_arready = 1; s_rvalid = 0;
        m1_araddr = 12'h000; m1_arvalid = 1; m1_rready = 1;
        q_gnt.push_back(64'd2); q_ar.push_back(mk(1, 32'h000)); q_rd.push_back(mk(1, 32'h2));
        @(negedge clk);
        chk("rd_arb_s_arvalid", 64'(s_arvalid), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_s_arvalid", 64'(s_arvalid), 64'd1);
        chk("rd_m1_arready", 64'(m1_arready), 64'd1);
        chk("rd_m0_arready", 64'(m0_arready), 64'd0);
        chk("rd_grant", 64'(grant), 64'd2);
        tick();
        m1_arvalid = 0;
        @(negedge clk);
        chk("rd_wait_busy", 64'(busy), 64'd1);
        chk("rd_wait_m1_rvalid", 64'(m1_rvalid), 64'd0);
        tick(); tick();
        s_rvalid = 1; s_rdata = 32'h0000_0002;
        @(negedge clk);
        chk("rd_m1_rvalid", 64'(m1_rvalid), 64'd1);
        chk("rd_m1_rdata", 64'(m1_rdata), 64'd2);
        chk("rd_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("rd_m0_rdata", 64'(m0_rdata), 64'd0);
        chk("rd_s_rready", 64'(s_rready), 64'd1);
        tick();
        s_rvalid = 0; s_rdata = 0; m1_rready = 0;
        @(negedge clk);
        chk("rd_end_grant", 64'(grant), 64'd0);

        // m0 write+read with m1 write waiting: m0 W, m1 W, m0 R
        s_rvalid = 1; s_rdata = 32'h77;
        m0_awaddr = 12'h050; m0_wdata = 32'hC0; m0_araddr = 12'h058;
        m1_awaddr = 12'h060; m1_wdata = 32'hD0;
        m0_awvalid = 1; m0_wvalid = 1; m0_arvalid = 1; m0_rready = 1;
        m1_awvalid = 1; m1_wvalid = 1;
        q_gnt.push_back(64'd1); q_gnt.push_back(64'd2); q_gnt.push_back(64'd1);
        q_aw.push_back(mk(0, 32'h050)); q_aw.push_back(mk(1, 32'h060));
        q_w.push_back(mk(0, 32'hC0)); q_w.push_back(mk(1, 32'hD0));
        q_ar.push_back(mk(0, 32'h058)); q_rd.push_back(mk(0, 32'h77));
        drain("mix_drain", 30);
        s_rvalid = 0; s_rdata = 0;

        // Reset in the middle of a write with AW already taken
        s_awready = 1; s_wready = 0;
        m0_awaddr = 12'h070; m0_wdata = 32'hE0; m0_awvalid = 1; m0_wvalid = 1;
        q_gnt.push_back(64'd1); q_aw.push_back(mk(0, 32'h070));
        tick();
        tick();
        s_awready = 0;
        @(negedge clk);
        chk("rm_pre_s_awvalid", 64'(s_awvalid), 64'd0);
        chk("rm_pre_grant", 64'(grant), 64'd1);
        rst_n = 0;
        tick();
        rst_n = 1; m0_awvalid = 0; m0_wvalid = 0;
        @(negedge clk);
        chk("rm_grant", 64'(grant), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_s_wvalid", 64'(s_wvalid), 64'd0);
        chk("rm_s_awvalid", 64'(s_awvalid), 64'd0);
        chk("rm_s_arvalid", 64'(s_arvalid), 64'd0);

        // Pointer back at master 0 after that reset
        s_awready = 1; s_wready = 1;
        m0_awaddr = 12'h080; m0_wdata = 32'hF0; m1_awaddr = 12'h090; m1_wdata = 32'hF1;
        m0_awvalid = 1; m0_wvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        q_gnt.push_back(64'd1); q_gnt.push_back(64'd2);
        q_aw.push_back(mk(0, 32'h080)); q_aw.push_back(mk(1, 32'h090));
        q_w.push_back(mk(0, 32'hF0)); q_w.push_back(mk(1, 32'hF1));
        drain("rm_ptr_drain", 20);

        @(negedge clk);
        chk("q_aw_empty", 64'(q_aw.size()), 64'd0);
        chk("q_w_empty", 64'(q_w.size()), 64'd0);
        chk("q_ar_empty", 64'(q_ar.size()), 64'd0);
        chk("q_rd_empty", 64'(q_rd.size()), 64'd0);
        chk("q_gnt_empty", 64'(q_gnt.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axilite_arbiter2.md
Name: axilite_arbiter2

Overview:
Two-master to one-slave AXI-Lite arbiter for the FIR configuration port. Master 0 is the Wishbone-to-AXI-Lite bridge (CPU path). Master 1 is a second requester, for example a DMA or sequencer that programs taps and data length and polls ap_done. The slave side connects to the single FIR AXI-Lite interface, which uses AW/W/AR/R channels only (no B channel). Arbitration is round-robin, and each grant is held until the whole transaction completes.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width
pDATA_WIDTH, 32, AXI-Lite data width
pCNT_WIDTH, 16, width of the perf counters (used only with AXIL_ARB_PERF_EN)

Ports:
clk  in  1  single clock
rst_n  in  1  reset, synchronous, active-low
m{0,1}_awvalid, m{0,1}_wvalid, m{0,1}_arvalid, m{0,1}_rready  in  1 each  master handshakes
m{0,1}_awready, m{0,1}_wready, m{0,1}_arready, m{0,1}_rvalid  out  1 each  master handshakes
m{0,1}_awaddr, m{0,1}_araddr  in  pADDR_WIDTH  master addresses
m{0,1}_wdata  in  pDATA_WIDTH  master write data
m{0,1}_rdata  out  pDATA_WIDTH  master read data
s_awvalid, s_wvalid, s_arvalid, s_rready  out  1  slave handshakes
s_awready, s_wready, s_arready, s_rvalid  in  1  slave handshakes
s_awaddr, s_araddr  out  pADDR_WIDTH  slave addresses
s_wdata  out  pDATA_WIDTH  slave write data
s_rdata  in  pDATA_WIDTH  slave read data
grant  out  2  one-hot owner; 00 = none
busy  out  1  a transaction is in progress
m{0,1}_xfer_cnt  out  pCNT_WIDTH  completed-transaction counts (optional feature)

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low.
  - On reset: state=IDLE, rr_ptr=0 (master 0 preferred), grant=00, busy=0, aw_done=w_done=ar_done=0.
  - Consequently every s_*valid, s_rready, m*_*ready, m*_rvalid is 0 and m*_rdata is 0.
  - Asserting reset mid-transaction abandons the transaction without completing it.
- Request definitions:
  - write request: m_awvalid | m_wvalid
  - read request: m_arvalid
  - If one master raises both, its write is served first.
- FSM states: IDLE, WR, RD.
- IDLE:
  - If any master requests, choose the master at rr_ptr if it requests, otherwise the other one.
  - Register the grant and go to WR or RD.
  - Arbitration costs exactly 1 cycle: the slave sees valid no earlier than the cycle after the request is first seen.
- WR (combinational routing from the granted master):
  - s_awvalid = m_awvalid & ~aw_done; s_wvalid = m_wvalid & ~w_done.
  - Slave readies are routed back to the granted master only.
  - aw_done sets on the AW handshake; w_done sets on the W handshake. The two may land in the same or different cycles, in either order.
  - When both are done (the current-cycle handshake counts): go to IDLE, clear the done flags, set rr_ptr to the other master.
- RD:
  - s_arvalid = m_arvalid & ~ar_done; ar_done sets on the AR handshake.
  - s_rready = m_rready of the granted master. s_rvalid/s_rdata are routed to the granted master only.
  - On the R handshake: go to IDLE, clear ar_done, flip rr_ptr.
- Non-granted master: all its readies, rvalid and rdata are 0. It holds its valids until granted.
- Outside IDLE the grant is held even if the owner drops a valid; a protocol violation does not release the bus.
- Both masters request in the same IDLE cycle: rr_ptr wins. Back-to-back requests from both therefore alternate 0,1,0,1.
- Minimum transaction: 1 IDLE cycle + 1 data cycle. A new grant can be issued in the IDLE cycle immediately after completion.

Optional Feature:
AXIL_ARB_PERF_EN:
- Defined: m0_xfer_cnt and m1_xfer_cnt each increment by 1 on every completed transaction of that master (write or read). They saturate at all-ones and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package axil_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_WR=2'd1, ST_RD=2'd2
  - grant encodings GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10
- One natural sub-module: axil_rr_pick, a 2-input round-robin picker. Inputs: req[1:0], rr_ptr. Output: one-hot grant. Combinational; the parent owns rr_ptr.

Test Plan:
- Single write: m0 drives aw/w (addr 0x010, data 0x00000005); slave readies held 1 → s_awvalid/s_wvalid rise 1 cycle later; m0 awready/wready pulse once; grant=01 for 1 cycle, then 00.
- Split handshake: s_awready high at cycle 2, s_wready high at cycle 5 → s_awvalid drops after cycle 2; the transaction ends at cycle 5; grant is held in between.
- Simultaneous contention: m0 and m1 both write after reset → m0 served first, then m1. Repeat → order 0,1,0,1. With the feature on, each xfer_cnt=2.
- Read with wait: m1 reads 0x000; slave returns rvalid 3 cycles after AR with rdata 0x00000002 → m1_rdata=0x00000002 during the handshake; m0_rvalid stays 0 throughout.
- Write+read from the same master (aw, w and ar all raised) → write completes first, then the read is granted; if the other master is waiting, it goes between them.
- Reset mid-transaction: rst_n low for 1 cycle while in WR with aw_done=1 → next cycle grant=00, all slave valids 0, rr_ptr=0.
